hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32E core (IF/ID/EX/MEM/WB, 16 registers, 4-bit register addresses). It sits beside id_stage and sequences the whole pipeline:
- tracks destination info of the instructions in EX/MEM/WB;
- detects load-use hazards and inserts bubbles;
- flushes on taken branches;
- freezes the pipeline while data memory is busy;
- produces registered EX forwarding selects.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/hazard_slot.sv | 62 ++++++
 rtl/hazard_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32E pipeline control blocks: forwarding selects,
// hazard FSM states and the register address width.
package riscv_pkg;

   localparam int REG_ADDR_W = 4;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_MEM_WAIT = 2'b01,
      ST_TIMEOUT  = 2'b10
   } hz_state_e;

endpackage

// File: rtl/hazard_slot.sv
// One pipeline tracking slot {valid, rd, reg_write, mem_read}.
// Priority: clear, then advance (load d_*), otherwise hold.
module hazard_slot #(
   parameter int ADDR_W = riscv_pkg::REG_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              advance,
   input  logic              d_valid,
   input  logic [ADDR_W-1:0] d_rd,
   input  logic              d_reg_write,
   input  logic              d_mem_read,
   output logic              q_valid,
   output logic [ADDR_W-1:0] q_rd,
   output logic              q_reg_write,
   output logic              q_mem_read
);

   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic              reg_write_q, reg_write_d;
   logic              mem_read_q, mem_read_d;

   always_comb begin
      valid_d     = valid_q;
      rd_d        = rd_q;
      reg_write_d = reg_write_q;
      mem_read_d  = mem_read_q;
      if (clear) begin
         valid_d     = 1'b0;
         rd_d        = '0;
         reg_write_d = 1'b0;
         mem_read_d  = 1'b0;
      end else if (advance) begin
         valid_d     = d_valid;
         rd_d        = d_rd;
         reg_write_d = d_reg_write;
         mem_read_d  = d_mem_read;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q     <= 1'b0;
         rd_q        <= '0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         rd_q        <= rd_d;
         reg_write_q <= reg_write_d;
         mem_read_q  <= mem_read_d;
      end
   end

   assign q_valid     = valid_q;
   assign q_rd        = rd_q;
   assign q_reg_write = reg_write_q;
   assign q_mem_read  = mem_read_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flush, dmem freeze, EX forwarding.
// Define HAZARD_TIMEOUT_EN to add the MEM_WAIT watchdog and sticky mem_timeout flag.
//
// state       | meaning
// ST_RUN      | pipeline advancing; branch flush and load-use bubble resolved here
// ST_MEM_WAIT | data memory busy, whole pipeline frozen
// ST_TIMEOUT  | one flush cycle after a memory timeout (HAZARD_TIMEOUT_EN only)
module hazard_ctrl #(
   parameter int REG_ADDR_W  = riscv_pkg::REG_ADDR_W,
   parameter int STALL_CNT_W = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   id_valid,
   input  logic [REG_ADDR_W-1:0]  id_rs1_addr,
   input  logic [REG_ADDR_W-1:0]  id_rs2_addr,
   input  logic                   id_uses_rs1,
   input  logic                   id_uses_rs2,
   input  logic [REG_ADDR_W-1:0]  id_rd_addr,
   input  logic                   id_reg_write,
   input  logic                   id_mem_read,
   input  logic                   ex_branch_taken,
   input  logic                   dmem_req,
   input  logic                   dmem_ack,
   output logic                   stall_if,
   output logic                   stall_id,
   output logic                   flush_id,
   output logic                   bubble_ex,
   output logic                   freeze,
   output logic [1:0]             fwd_a_sel,
   output logic [1:0]             fwd_b_sel,
   output logic [STALL_CNT_W-1:0] stall_cycles,
   output logic                   mem_timeout
);
   import riscv_pkg::*;

   hz_state_e              state_q, state_d;
   logic [1:0]             fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic                   slot_clr, advance, to_expire, mem_busy, load_use;
   logic                   ex_valid, ex_rw, ex_ld, mem_valid, mem_rw, mem_ld;
   logic                   wb_valid, wb_rw, wb_ld, ex_live, mem_live;
   logic [REG_ADDR_W-1:0]  ex_rd, mem_rd, wb_rd;

   assign advance = ~freeze;

   hazard_slot #(.ADDR_W(REG_ADDR_W)) u_slot_ex (
      .clk(clk), .rst(rst), .clear(slot_clr), .advance(advance),
      .d_valid(id_valid & ~bubble_ex), .d_rd(id_rd_addr),
      .d_reg_write(id_reg_write), .d_mem_read(id_mem_read),
      .q_valid(ex_valid), .q_rd(ex_rd), .q_reg_write(ex_rw), .q_mem_read(ex_ld)
   );

   hazard_slot #(.ADDR_W(REG_ADDR_W)) u_slot_mem (
      .clk(clk), .rst(rst), .clear(slot_clr), .advance(advance),
      .d_valid(ex_valid), .d_rd(ex_rd), .d_reg_write(ex_rw), .d_mem_read(ex_ld),
      .q_valid(mem_valid), .q_rd(mem_rd), .q_reg_write(mem_rw), .q_mem_read(mem_ld)
   );

   hazard_slot #(.ADDR_W(REG_ADDR_W)) u_slot_wb (
      .clk(clk), .rst(rst), .clear(slot_clr), .advance(advance),
      .d_valid(mem_valid), .d_rd(mem_rd), .d_reg_write(mem_rw), .d_mem_read(mem_ld),
      .q_valid(wb_valid), .q_rd(wb_rd), .q_reg_write(wb_rw), .q_mem_read(wb_ld)
   );

   // WB occupancy is tracked for pipeline bookkeeping; nothing here consumes it yet.
   logic unused_wb;
   assign unused_wb = ^{wb_valid, wb_rd, wb_rw, wb_ld, mem_ld};

   assign ex_live  = ex_valid & ex_rw & (ex_rd != '0);
   assign mem_live = mem_valid & mem_rw & (mem_rd != '0);
   assign load_use = ex_live & ex_ld & id_valid &
                     ((id_uses_rs1 & (id_rs1_addr == ex_rd)) |
                      (id_uses_rs2 & (id_rs2_addr == ex_rd)));
   assign mem_busy = ~dmem_ack & (dmem_req | (state_q == ST_MEM_WAIT));

   function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                          input logic                  use_src,
                                          input logic                  ex_ok,
                                          input logic [REG_ADDR_W-1:0] ex_dst,
                                          input logic                  mem_ok,
                                          input logic [REG_ADDR_W-1:0] mem_dst);
      logic [1:0] sel;
      sel = FWD_REG;
      if (use_src && ex_ok && (ex_dst == src))
         sel = FWD_MEM;
      else if (use_src && mem_ok && (mem_dst == src))
         sel = FWD_WB;
      return sel;
   endfunction

`ifdef HAZARD_TIMEOUT_EN
   localparam int              TO_W      = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(MEM_TIMEOUT - 1);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            mem_timeout_q, mem_timeout_d;

   assign to_expire = (state_q == ST_MEM_WAIT) & ~dmem_ack & (to_cnt_q == '0);

   always_comb begin
      to_cnt_d = TO_RELOAD;
      if ((state_q == ST_MEM_WAIT) && !dmem_ack && (to_cnt_q != '0))
         to_cnt_d = to_cnt_q - TO_W'(1);
      mem_timeout_d = mem_timeout_q | to_expire;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt_q      <= TO_RELOAD;
         mem_timeout_q <= 1'b0;
      end else begin
         to_cnt_q      <= to_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign mem_timeout = mem_timeout_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (MEM_TIMEOUT == 0);
   assign to_expire   = 1'b0;
   assign mem_timeout = 1'b0;
`endif

   always_comb begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      flush_id  = 1'b0;
      bubble_ex = 1'b0;
      freeze    = 1'b0;
      slot_clr  = 1'b0;
      state_d   = state_q;
      case (state_q)
         // The ack cycle of MEM_WAIT already advances, so a branch or load-use held in
         // EX during the wait is resolved in that cycle.
         ST_RUN, ST_MEM_WAIT: begin
            if (mem_busy) begin
               freeze   = 1'b1;
               stall_if = 1'b1;
               stall_id = 1'b1;
               state_d  = ST_MEM_WAIT;
               if (to_expire) begin
                  slot_clr = 1'b1;
                  state_d  = ST_TIMEOUT;
               end
            end else begin
               state_d = ST_RUN;
               if (ex_branch_taken) begin
                  flush_id  = 1'b1;
                  bubble_ex = 1'b1;
               end else if (load_use) begin
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  bubble_ex = 1'b1;
               end
            end
         end
`ifdef HAZARD_TIMEOUT_EN
         ST_TIMEOUT: begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
            state_d   = ST_RUN;
         end
`endif
         default: state_d = ST_RUN;
      endcase
      if (rst) begin
         stall_if  = 1'b0;
         stall_id  = 1'b0;
         flush_id  = 1'b0;
         bubble_ex = 1'b0;
         freeze    = 1'b0;
         slot_clr  = 1'b0;
      end
   end

   always_comb begin
      fwd_a_d = fwd_a_q;
      fwd_b_d = fwd_b_q;
      if (!freeze) begin
         if (id_valid && !bubble_ex) begin
            fwd_a_d = fwd_sel(id_rs1_addr, id_uses_rs1, ex_live & ~ex_ld, ex_rd, mem_live, mem_rd);
            fwd_b_d = fwd_sel(id_rs2_addr, id_uses_rs2, ex_live & ~ex_ld, ex_rd, mem_live, mem_rd);
         end else begin
            fwd_a_d = FWD_REG;
            fwd_b_d = FWD_REG;
         end
      end
      stall_cycles_d = stall_cycles_q;
      if (stall_if && (stall_cycles_q != '1))
         stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_RUN;
         fwd_a_q        <= FWD_REG;
         fwd_b_q        <= FWD_REG;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         fwd_a_q        <= fwd_a_d;
         fwd_b_q        <= fwd_b_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign fwd_a_sel    = fwd_a_q;
   assign fwd_b_sel    = fwd_b_q;
   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios plus a randomized
// run against a behavioural pipeline model.
module tb_hazard_ctrl;
   localparam int RW = 4;
   localparam int SW = 16;
   localparam int MT = 8;
`ifdef HAZARD_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
   logic [RW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic          ex_branch_taken, dmem_req, dmem_ack;
   logic          stall_if, stall_id, flush_id, bubble_ex, freeze, mem_timeout;
   logic [1:0]    fwd_a_sel, fwd_b_sel;
   logic [SW-1:0] stall_cycles;
   logic [4:0]    ctl;

   int errors = 0;
   int checks = 0;

   hazard_ctrl #(.REG_ADDR_W(RW), .STALL_CNT_W(SW), .MEM_TIMEOUT(MT)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd_addr(id_rd_addr),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
      .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .bubble_ex(bubble_ex),
      .freeze(freeze), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   // {stall_if, stall_id, flush_id, bubble_ex, freeze}
   assign ctl = {stall_if, stall_id, flush_id, bubble_ex, freeze};

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_id(input logic v, input logic [RW-1:0] rs1, input logic u1,
                         input logic [RW-1:0] rs2, input logic u2,
                         input logic [RW-1:0] rd, input logic rw, input logic ld);
      id_valid = v; id_rs1_addr = rs1; id_uses_rs1 = u1; id_rs2_addr = rs2;
      id_uses_rs2 = u2; id_rd_addr = rd; id_reg_write = rw; id_mem_read = ld;
   endtask

   task automatic do_reset();
      set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      set_id(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);   // ADDI x2,x0,5
      step();
      set_id(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);   // ADDI x5,x2,1
      step();
      dmem_req = 1'b1;
      step();
      step();
      #1;
      checks++; if (ctl !== 5'b11001) begin errors++; $display("FAIL rst_pre_ctl: got %b want %b", ctl, 5'b11001); end
      checks++; if (stall_cycles !== 16'd2) begin errors++; $display("FAIL rst_pre_cnt: got %0d want 2", stall_cycles); end
      checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL rst_pre_fwd_a: got %b want 01", fwd_a_sel); end
      rst = 1'b1;
      #1;
      checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL rst_ctl: got %b want 00000", ctl); end
      checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin errors++; $display("FAIL rst_fwd: got %b want 0000", {fwd_a_sel, fwd_b_sel}); end
      checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", stall_cycles); end
      checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b want 0", mem_timeout); end
      dmem_req = 1'b0;
      id_valid = 1'b0;
      step();
      rst = 1'b0;
      #1;
      checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL rst_state_run: got %b want 00000", ctl); end
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1);   // LW x3,0(x2)
      #1;
      checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL lu_first: got %b want 00000", ctl); end
      step();
      set_id(1'b1, 4'd3, 1'b1, 4'd5, 1'b1, 4'd4, 1'b1, 1'b0);   // ADD x4,x3,x5
      #1;
      checks++; if (ctl !== 5'b11010) begin errors++; $display("FAIL lu_stall: got %b want 11010", ctl); end
      step();
      #1;
      checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL lu_release: got %b want 00000", ctl); end
      step();
      id_valid = 1'b0;
      #1;
      checks++; if (fwd_a_sel !== 2'b10) begin errors++; $display("FAIL lu_fwd_a: got %b want 10", fwd_a_sel); end
      checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL lu_fwd_b: got %b want 00", fwd_b_sel); end
      checks++; if (stall_cycles !== 16'd1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", stall_cycles); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      set_id(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);   // ADDI x2,x0,5
      step();
      set_id(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);   // ADDI x2,x2,1
      #1;
      checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL b2b_no_stall: got %b want 00000", ctl); end
      step();
      checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL b2b_fwd_a2: got %b want 01", fwd_a_sel); end
      set_id(1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 4'd6, 1'b1, 1'b0);   // ADD x6,x2,x2
      step();
      id_valid = 1'b0;
      #1;
      checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0101) begin errors++; $display("FAIL b2b_fwd3: got %b want 0101", {fwd_a_sel, fwd_b_sel}); end
      checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL b2b_cnt: got %0d want 0", stall_cycles); end
   endtask

   task automatic test_x0();
      do_reset();
      set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1);   // LW x0,0(x1)
      step();
      set_id(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd1, 1'b1, 1'b0);   // ADD x1,x0,x0
      #1;
      checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL x0_no_stall: got %b want 00000", ctl); end
      step();
      id_valid = 1'b0;
      #1;
      checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin errors++; $display("FAIL x0_fwd: got %b want 0000", {fwd_a_sel, fwd_b_sel}); end
   endtask

   task automatic test_branch_vs_hazard();
      do_reset();
      set_id(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1);   // LW x3,0(x2)
      step();
      set_id(1'b1, 4'd3, 1'b1, 4'd5, 1'b1, 4'd4, 1'b1, 1'b0);   // ADD x4,x3,x5 (wrong path)
      ex_branch_taken = 1'b1;
      #1;
      checks++; if (ctl !== 5'b00110) begin errors++; $display("FAIL br_flush: got %b want 00110", ctl); end
      step();
      ex_branch_taken = 1'b0;
      id_valid = 1'b0;
      #1;
      checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL br_cnt: got %0d want 0", stall_cycles); end
      checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL br_fwd: got %b want 00", fwd_a_sel); end
   endtask

   task automatic test_mem_wait();
      do_reset();
      set_id(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);   // ADDI x2,x0,5
      step();
      set_id(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);   // ADDI x7,x2,1
      step();
      set_id(1'b1, 4'd7, 1'b1, 4'd2, 1'b1, 4'd8, 1'b1, 1'b0);   // ADD x8,x7,x2
      dmem_req = 1'b1;
      dmem_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (ctl !== 5'b11001) begin errors++; $display("FAIL mw_freeze[%0d]: got %b want 11001", i, ctl); end
         checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL mw_fwd_hold[%0d]: got %b want 01", i, fwd_a_sel); end
         step();
      end
      dmem_ack = 1'b1;
      #1;
      checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL mw_ack: got %b want 00000", ctl); end
      step();
      dmem_req = 1'b0;
      dmem_ack = 1'b0;
      id_valid = 1'b0;
      #1;
      checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0110) begin errors++; $display("FAIL mw_fwd_after: got %b want 0110", {fwd_a_sel, fwd_b_sel}); end
      checks++; if (stall_cycles !== 16'd5) begin errors++; $display("FAIL mw_cnt: got %0d want 5", stall_cycles); end
   endtask

`ifdef HAZARD_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      set_id(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);   // ADDI x2,x0,5
      step();
      id_valid = 1'b0;
      dmem_req = 1'b1;
      for (int i = 0; i <= MT; i++) begin
         #1;
         checks++; if (ctl !== 5'b11001) begin errors++; $display("FAIL to_wait[%0d]: got %b want 11001", i, ctl); end
         checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL to_early[%0d]: got %b want 0", i, mem_timeout); end
         step();
      end
      dmem_req = 1'b0;
      set_id(1'b1, 4'd2, 1'b1, 4'd0, 1'b1, 4'd3, 1'b1, 1'b0);   // ADD x3,x2,x0
      #1;
      checks++; if (ctl !== 5'b00110) begin errors++; $display("FAIL to_flush: got %b want 00110", ctl); end
      checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b want 1", mem_timeout); end
      step();
      #1;
      checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL to_run: got %b want 00000", ctl); end
      step();
      id_valid = 1'b0;
      #1;
      checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL to_slots_cleared: got %b want 00", fwd_a_sel); end
      checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", mem_timeout); end
   endtask
`endif

   // Behavioural model: index 0=EX, 1=MEM, 2=WB; m_st 0=running, 1=waiting on memory, 2=timeout flush.
   logic          m_v[3], m_rw[3], m_ld[3];
   logic [RW-1:0] m_rd[3];
   int            m_st, m_wcnt;
   int unsigned   m_sc;
   logic [1:0]    m_fa, m_fb;
   logic          m_to;

   function automatic logic [1:0] m_fwd(input logic [RW-1:0] r, input logic u);
      if (!u) return 2'b00;
      if (m_v[0] && m_rw[0] && m_rd[0] != 0 && !m_ld[0] && m_rd[0] == r) return 2'b01;
      if (m_v[1] && m_rw[1] && m_rd[1] != 0 && m_rd[1] == r) return 2'b10;
      return 2'b00;
   endfunction

   task automatic test_random();
      logic [4:0] e;
      logic       busy, hz, to_now;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         m_v[k] = 1'b0; m_rw[k] = 1'b0; m_ld[k] = 1'b0; m_rd[k] = '0;
      end
      m_st = 0; m_wcnt = 0; m_sc = 0; m_fa = 2'b00; m_fb = 2'b00; m_to = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         set_id(1'($urandom_range(9) < 8), 4'($urandom_range(3)), 1'($urandom_range(1)),
                4'($urandom_range(3)), 1'($urandom_range(1)), 4'($urandom_range(3)),
                1'($urandom_range(3) != 0), 1'($urandom_range(9) < 4));
         ex_branch_taken = 1'($urandom_range(9) == 0);
         dmem_req        = 1'($urandom_range(4) == 0);
         dmem_ack        = 1'($urandom_range(9) < 4);
         #1;
         busy = !dmem_ack && (m_st == 1 || dmem_req);
         hz = m_v[0] && m_ld[0] && m_rw[0] && m_rd[0] != 0 && id_valid &&
              ((id_uses_rs1 && id_rs1_addr == m_rd[0]) || (id_uses_rs2 && id_rs2_addr == m_rd[0]));
         to_now = 1'b0;
         if (m_st == 2) e = 5'b00110;
         else if (busy) begin
            e = 5'b11001;
            to_now = TO_EN && m_st == 1 && m_wcnt == MT - 1;
         end
         else if (ex_branch_taken) e = 5'b00110;
         else if (hz) e = 5'b11010;
         else e = 5'b00000;
         checks++; if (ctl !== e) begin errors++; $display("FAIL rnd_ctl[%0d]: got %b want %b", n, ctl, e); end
         checks++; if (fwd_a_sel !== m_fa) begin errors++; $display("FAIL rnd_fwd_a[%0d]: got %b want %b", n, fwd_a_sel, m_fa); end
         checks++; if (fwd_b_sel !== m_fb) begin errors++; $display("FAIL rnd_fwd_b[%0d]: got %b want %b", n, fwd_b_sel, m_fb); end
         checks++; if (stall_cycles !== SW'(m_sc)) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, stall_cycles, m_sc); end
         checks++; if (mem_timeout !== m_to) begin errors++; $display("FAIL rnd_timeout[%0d]: got %b want %b", n, mem_timeout, m_to); end
         // advance the model by one clock
         if (!e[0]) begin
            if (id_valid && !e[1]) begin
               m_fa = m_fwd(id_rs1_addr, id_uses_rs1);
               m_fb = m_fwd(id_rs2_addr, id_uses_rs2);
            end else begin
               m_fa = 2'b00; m_fb = 2'b00;
            end
            for (int k = 2; k > 0; k--) begin
               m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_rw[k] = m_rw[k-1]; m_ld[k] = m_ld[k-1];
            end
            m_v[0] = id_valid && !e[1]; m_rd[0] = id_rd_addr; m_rw[0] = id_reg_write; m_ld[0] = id_mem_read;
         end
         if (to_now) begin
            for (int k = 0; k < 3; k++) m_v[k] = 1'b0;
            m_to = 1'b1;
         end
         if (e[4] && m_sc != 65535) m_sc++;
         if (m_st == 2) m_st = 0;
         else if (to_now) m_st = 2;
         else if (busy) begin
            if (m_st == 1) m_wcnt++;
            else m_wcnt = 0;
            m_st = 1;
         end else m_st = 0;
         step();
      end
   endtask

   initial begin
      rst = 1'b1;
      set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
      step();
      test_reset();
      test_load_use();
      test_back_to_back();
      test_x0();
      test_branch_vs_hazard();
      test_mem_wait();
`ifdef HAZARD_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
